// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//
// Loads a small program of {opcode, operand} words, then replays it one
// instruction per clock into an external stack ALU.  A shadow copy of the
// stack depth lets the sequencer refuse instructions that would overflow or
// underflow the stack before they are ever driven.  When the program ends
// (halt opcode or last loaded word), the final top of stack is captured.
//
// Opcodes: 0 nop, 1 halt, 2/3 illegal, 4 add, 5 mul, 6 push, 7 pop.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   load_valid    program word offered
//   load_data     {opcode[2:0], operand[WIDTH-1:0]}
//   load_ready    word accepted when high together with load_valid
//   start         single-cycle request to run the loaded program
//   stk_opcode    opcode to the stack ALU (0 when not issuing)
//   stk_in        operand to the stack ALU (held when not issuing)
//   stk_out       stack top value from the ALU
//   stk_overflow  overflow flag from the ALU
//   busy          high while running or draining
//   done          one-cycle pulse on successful completion
//   error         sticky fault flag, cleared by the next accepted start
//   err_code      1 overflow, 2 underflow, 3 illegal opcode
//   result        top of stack captured at completion
// ---------------------------------------------------------------------------
module stack_sequencer #(
    parameter int WIDTH       = 8,
    parameter int PROG_DEPTH  = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH+2:0] load_data,
    output logic             load_ready,
    input  logic             start,
    output logic [2:0]       stk_opcode,
    output logic [WIDTH-1:0] stk_in,
    input  logic [WIDTH-1:0] stk_out,
    input  logic             stk_overflow,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [WIDTH-1:0] result
);

    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int CW = AW + 1;                   // counts 0..PROG_DEPTH
    localparam int DW = $clog2(STACK_DEPTH + 1);  // counts 0..STACK_DEPTH

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_HALT = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_PUSH = 3'd6;
    localparam logic [2:0] OP_POP  = 3'd7;

    localparam logic [1:0] E_OVF   = 2'd1;
    localparam logic [1:0] E_UNDER = 2'd2;
    localparam logic [1:0] E_ILL   = 2'd3;

    // Program buffer: written in IDLE, read through a register so it maps
    // onto block RAM.
    logic [WIDTH+2:0] prog [PROG_DEPTH];
    logic [WIDTH+2:0] instr_reg;
    logic [AW-1:0]    rd_addr;
    logic             wr_en;

    logic [1:0]       state_reg,      state_next;
    logic [CW-1:0]    count_reg,      count_next;
    logic [CW-1:0]    pc_reg,         pc_next;
    logic [DW-1:0]    depth_reg,      depth_next;
    logic [2:0]       stk_opcode_reg, stk_opcode_next;
    logic [WIDTH-1:0] stk_in_reg,     stk_in_next;
    logic [WIDTH-1:0] result_reg,     result_next;
    logic             done_reg,       done_next;
    logic             error_reg,      error_next;
    logic [1:0]       err_code_reg,   err_code_next;

    logic [2:0]       instr_op;
    logic [WIDTH-1:0] instr_arg;
    logic [CW-1:0]    pc_plus1;
    logic             end_prog;
    logic [1:0]       pre_fault;
    logic             take_fault;
    logic [1:0]       fault_code;

    assign instr_op  = instr_reg[WIDTH+2:WIDTH];
    assign instr_arg = instr_reg[WIDTH-1:0];
    assign pc_plus1  = pc_reg + CW'(1);
    // pc==count is checked first: the word at prog[count] is stale.
    assign end_prog  = (pc_reg == count_reg) || (instr_op == OP_HALT);

    assign load_ready = (state_reg == S_IDLE) && (count_reg < CW'(PROG_DEPTH));
    assign busy       = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign stk_opcode = stk_opcode_reg;
    assign stk_in     = stk_in_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign err_code   = err_code_reg;
    assign result     = result_reg;

    // Precondition check against the shadow depth of the current instruction.
    always_comb begin
        pre_fault = 2'd0;
        case (instr_op)
            OP_PUSH:        if (depth_reg == DW'(STACK_DEPTH)) pre_fault = E_OVF;
            OP_POP:         if (depth_reg == '0)               pre_fault = E_UNDER;
            OP_ADD, OP_MUL: if (depth_reg < DW'(2))            pre_fault = E_UNDER;
            3'd2, 3'd3:     pre_fault = E_ILL;
            default:        pre_fault = 2'd0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        pc_next         = pc_reg;
        depth_next      = depth_reg;
        stk_opcode_next = OP_NOP;
        stk_in_next     = stk_in_reg;
        result_next     = result_reg;
        done_next       = 1'b0;
        error_next      = error_reg;
        err_code_next   = err_code_reg;
        wr_en           = 1'b0;
        rd_addr         = '0;
        take_fault      = 1'b0;
        fault_code      = 2'd0;

        case (state_reg)
            S_IDLE: begin
                if (load_valid && load_ready) begin
                    wr_en      = 1'b1;
                    count_next = count_reg + CW'(1);
                end
                // rd_addr is 0 here, so prog[0] is already in instr_reg
                // when RUN begins.
                if (start && (count_reg != '0)) begin
                    state_next    = S_RUN;
                    pc_next       = '0;
                    depth_next    = '0;
                    error_next    = 1'b0;
                    err_code_next = 2'd0;
                end
            end
            S_RUN: begin
                // Prefetch the next word so it lands in instr_reg on time.
                rd_addr = pc_plus1[AW-1:0];
                if (!end_prog && (pre_fault != 2'd0)) begin
                    take_fault = 1'b1;
                    fault_code = pre_fault;
                end else if (stk_overflow) begin
                    take_fault = 1'b1;
                    fault_code = E_OVF;
                end else if (end_prog) begin
                    state_next = S_DRAIN;
                end else begin
                    stk_opcode_next = instr_op;
                    stk_in_next     = instr_arg;
                    pc_next         = pc_plus1;
                    case (instr_op)
                        OP_PUSH:                depth_next = depth_reg + DW'(1);
                        OP_POP, OP_ADD, OP_MUL: depth_next = depth_reg - DW'(1);
                        default:                depth_next = depth_reg;
                    endcase
                end
            end
            S_DRAIN: begin
                // The last issued operation has settled in the ALU by now.
                if (stk_overflow) begin
                    take_fault = 1'b1;
                    fault_code = E_OVF;
                end else begin
                    result_next = stk_out;
                    done_next   = 1'b1;
                    count_next  = '0;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (take_fault) begin
            state_next      = S_IDLE;
            error_next      = 1'b1;
            err_code_next   = fault_code;
            count_next      = '0;
            stk_opcode_next = OP_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            prog[count_reg[AW-1:0]] <= load_data;
        end
        instr_reg <= prog[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            pc_reg         <= '0;
            depth_reg      <= '0;
            stk_opcode_reg <= OP_NOP;
            stk_in_reg     <= '0;
            result_reg     <= '0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            err_code_reg   <= 2'd0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            pc_reg         <= pc_next;
            depth_reg      <= depth_next;
            stk_opcode_reg <= stk_opcode_next;
            stk_in_reg     <= stk_in_next;
            result_reg     <= result_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
            err_code_reg   <= err_code_next;
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_sequencer
//
// Scoreboard bench for stack_sequencer.  Stimulus loads directed programs and
// queues the hand-computed per-cycle observations (gap, issue, done, error);
// a forked monitor classifies what the DUT shows at every falling edge and
// compares it with the head of the queue.  A small behavioral stack answers
// the issued opcodes so stk_out carries real values.
// ---------------------------------------------------------------------------
module tb_stack_sequencer;

    localparam logic [1:0] K_ISSUE = 2'd0;
    localparam logic [1:0] K_DONE  = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;
    localparam logic [1:0] K_GAP   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] op;
        logic [7:0] val;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [10:0] load_data;
    logic        load_ready;
    logic        start;
    logic [2:0]  stk_opcode;
    logic [7:0]  stk_in;
    logic [7:0]  stk_out;
    logic        stk_overflow;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [7:0]  result;

    ev_t        exp_q[$];
    logic [7:0] stk_q[$];
    int         errors = 0;
    int         checks = 0;

    stack_sequencer #(
        .WIDTH(8),
        .PROG_DEPTH(16),
        .STACK_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .start(start),
        .stk_opcode(stk_opcode),
        .stk_in(stk_in),
        .stk_out(stk_out),
        .stk_overflow(stk_overflow),
        .busy(busy),
        .done(done),
        .error(error),
        .err_code(err_code),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioral downstream stack.
    always @(posedge clk) begin
        if (!rst_n || start) begin
            stk_q.delete();
        end else begin
            case (stk_opcode)
                3'd6: stk_q.push_back(stk_in);
                3'd7: if (stk_q.size() > 0) void'(stk_q.pop_back());
                3'd4: if (stk_q.size() > 1) stk_q.push_back(8'(stk_q.pop_back() + stk_q.pop_back()));
                3'd5: if (stk_q.size() > 1) stk_q.push_back(8'(stk_q.pop_back() * stk_q.pop_back()));
                default: ;
            endcase
        end
        stk_out <= (stk_q.size() > 0) ? stk_q[$] : 8'd0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic ev_match(input ev_t g, input ev_t w);
        if (g.kind != w.kind) return 1'b0;
        case (g.kind)
            K_ISSUE: return (g.op == w.op) && ((g.op != 3'd6) || (g.val == w.val));
            K_DONE, K_ERR: return g.val == w.val;
            default: return 1'b1;
        endcase
    endfunction

    task automatic monitor();
        logic err_prev;
        logic have;
        ev_t  got;
        ev_t  want;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                err_prev = 1'b0;
            end else begin
                have = 1'b1;
                got  = '0;
                if (done)                   got = {K_DONE, 3'd0, result};
                else if (error && !err_prev) got = {K_ERR, 3'd0, 6'd0, err_code};
                else if (stk_opcode != 3'd0) got = {K_ISSUE, stk_opcode, stk_in};
                else if (busy)              got = {K_GAP, 3'd0, 8'd0};
                else                        have = 1'b0;
                err_prev = error;
                if (have) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard: unexpected kind=%0d op=%0d val=%0d, expected nothing",
                                 got.kind, got.op, got.val);
                    end else begin
                        want = exp_q.pop_front();
                        if (!ev_match(got, want)) begin
                            errors++;
                            $display("FAIL scoreboard: got kind=%0d op=%0d val=%0d, expected kind=%0d op=%0d val=%0d",
                                     got.kind, got.op, got.val, want.kind, want.op, want.val);
                        end
                    end
                end
            end
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [2:0] op, input logic [7:0] v);
        exp_q.push_back({k, op, v});
    endtask

    task automatic load_word(input logic [2:0] op, input logic [7:0] arg);
        load_valid = 1'b1;
        load_data  = {op, arg};
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_not_busy(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now(name);
    endtask

    task automatic wait_opcode(input string name, input logic [2:0] op, input int budget);
        int n = 0;
        while (stk_opcode != op && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (stk_opcode != op) fail_now(name);
    endtask

    task automatic finish_test(input string name);
        repeat (2) @(negedge clk);
        chk({name, " queue drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " busy"},       busy,       0);
        chk({name, " done"},       done,       0);
        chk({name, " error"},      error,      0);
        chk({name, " err_code"},   err_code,   0);
        chk({name, " stk_opcode"}, stk_opcode, 0);
        chk({name, " stk_in"},     stk_in,     0);
        chk({name, " result"},     result,     0);
        chk({name, " load_ready"}, load_ready, 1);
    endtask

    initial begin
        rst_n        = 1'b1;
        load_valid   = 1'b0;
        load_data    = '0;
        start        = 1'b0;
        stk_overflow = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Start with an empty program is ignored
        pulse_start();
        chk("empty start busy", busy, 0);

        // push 1, push 2, add, halt
        load_word(3'd6, 8'd1);
        load_word(3'd6, 8'd2);
        load_word(3'd4, 8'd0);
        load_word(3'd1, 8'd0);
        expect_ev(K_GAP, 3'd0, 8'd0);
        expect_ev(K_ISSUE, 3'd6, 8'd1);
        expect_ev(K_ISSUE, 3'd6, 8'd2);
        expect_ev(K_ISSUE, 3'd4, 8'd0);
        expect_ev(K_GAP, 3'd0, 8'd0);
        expect_ev(K_DONE, 3'd0, 8'd3);
        pulse_start();
        wait_not_busy("add run timeout", 50);
        finish_test("add");
        chk("add error", error, 0);
        chk("add result", result, 3);
        chk("add load_ready after run", load_ready, 1);

        // push 5, add -> underflow before add is driven
        load_word(3'd6, 8'd5);
        load_word(3'd4, 8'd0);
        expect_ev(K_GAP, 3'd0, 8'd0);
        expect_ev(K_ISSUE, 3'd6, 8'd5);
        expect_ev(K_ERR, 3'd0, 8'd2);
        pulse_start();
        wait_not_busy("underflow run timeout", 50);
        finish_test("underflow");
        chk("underflow error", error, 1);
        chk("underflow err_code", err_code, 2);

        // nine pushes -> eight issued, capacity fault
        for (int i = 1; i <= 9; i++) load_word(3'd6, 8'(i));
        expect_ev(K_GAP, 3'd0, 8'd0);
        for (int i = 1; i <= 8; i++) expect_ev(K_ISSUE, 3'd6, 8'(i));
        expect_ev(K_ERR, 3'd0, 8'd1);
        pulse_start();
        wait_not_busy("capacity run timeout", 50);
        finish_test("capacity");
        chk("capacity err_code", err_code, 1);

        // Full buffer: 16 words accepted, 17th (halt) dropped
        chk("fill load_ready before", load_ready, 1);
        for (int i = 1; i <= 8; i++) load_word(3'd6, 8'(i));
        for (int i = 0; i < 7; i++) load_word(3'd4, 8'd0);
        load_word(3'd6, 8'd9);
        chk("fill load_ready full", load_ready, 0);
        load_word(3'd1, 8'd0);
        expect_ev(K_GAP, 3'd0, 8'd0);
        for (int i = 1; i <= 8; i++) expect_ev(K_ISSUE, 3'd6, 8'(i));
        for (int i = 0; i < 7; i++) expect_ev(K_ISSUE, 3'd4, 8'd0);
        expect_ev(K_ISSUE, 3'd6, 8'd9);
        expect_ev(K_GAP, 3'd0, 8'd0);
        expect_ev(K_DONE, 3'd0, 8'd9);
        pulse_start();
        wait_not_busy("fill run timeout", 100);
        finish_test("fill");
        chk("fill result", result, 9);

        // push 200, push 200, mul with stk_overflow raised during RUN
        load_word(3'd6, 8'd200);
        load_word(3'd6, 8'd200);
        load_word(3'd5, 8'd0);
        expect_ev(K_GAP, 3'd0, 8'd0);
        expect_ev(K_ISSUE, 3'd6, 8'd200);
        expect_ev(K_ISSUE, 3'd6, 8'd200);
        expect_ev(K_ISSUE, 3'd5, 8'd0);
        expect_ev(K_ERR, 3'd0, 8'd1);
        pulse_start();
        wait_opcode("overflow mul wait", 3'd5, 20);
        stk_overflow = 1'b1;
        @(negedge clk);
        chk("overflow stk_opcode", stk_opcode, 0);
        chk("overflow error", error, 1);
        chk("overflow err_code", err_code, 1);
        chk("overflow busy", busy, 0);
        stk_overflow = 1'b0;
        finish_test("overflow");

        // Asynchronous reset in the middle of RUN
        load_word(3'd6, 8'd7);
        load_word(3'd6, 8'd8);
        load_word(3'd6, 8'd9);
        load_word(3'd1, 8'd0);
        expect_ev(K_GAP, 3'd0, 8'd0);
        expect_ev(K_ISSUE, 3'd6, 8'd7);
        pulse_start();
        wait_opcode("midrun push wait", 3'd6, 20);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrun done after release", done, 0);
        chk("midrun busy after release", busy, 0);
        finish_test("midrun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
